// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller for MEM load/store and IF fetch requests.
// Optional IO-space store throttling via MEM_CTRL_IO_WAIT_EN (adds io_buffer_full).
module mem_ctrl #(
    parameter int RAM_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      save,
    input  logic [31:0]               sl_reg_address,
    input  logic [31:0]               sl_data,
    input  logic [2:0]                sl_data_length,
    input  logic                      sl_data_signed,
    output logic                      mem_ctrl_done,
    output logic [31:0]               mem_ctrl_data,
    input  logic                      if_req,
    input  logic [31:0]               if_addr,
    output logic                      if_done,
    output logic [31:0]               if_inst,
    output logic [RAM_ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]                mem_dout,
    output logic                      mem_wr,
    input  logic [7:0]                mem_din
`ifdef MEM_CTRL_IO_WAIT_EN
    ,
    input  logic                      io_buffer_full
`endif
);

    localparam int AW = RAM_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      len_q, len_d;
    logic            sgn_q, sgn_d;
    logic [31:0]     wdat_q, wdat_d;
    logic            own_q, own_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [31:0]     buf_q, buf_d;
    logic [AW-1:0]   mem_a_q, mem_a_d;
    logic [7:0]      dout_q, dout_d;
    logic            wr_q, wr_d;
    logic            done_q, done_d;
    logic            ifdone_q, ifdone_d;
    logic [31:0]     data_q, data_d;
    logic [31:0]     inst_q, inst_d;
    logic            hold_idle, hold_wr;
    logic [1:0]      rd_idx;
    logic [31:0]     word;
    logic [7:0]      wbyte;
    logic [2:0]      req_len;

`ifdef MEM_CTRL_IO_WAIT_EN
    logic io_q, io_d;
    assign hold_idle = io_buffer_full & (sl_reg_address[17:16] == 2'b11);
    assign hold_wr   = io_buffer_full & io_q;
`else
    assign hold_idle = 1'b0;
    assign hold_wr   = 1'b0;
`endif

    assign req_len = (sl_data_length == 3'd1) ? 3'd1 :
                     (sl_data_length == 3'd2) ? 3'd2 : 3'd4;

    // cnt_q counts READ cycles from 1; byte k arrives when cnt_q == k+2
    assign rd_idx = cnt_q[1:0] - 2'd2;
    assign wbyte  = wdat_q[{cnt_q[1:0], 3'b000} +: 8];

    always_comb begin
        word = buf_q;
        word[{rd_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        sgn_d    = sgn_q;
        wdat_d   = wdat_q;
        own_d    = own_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        mem_a_d  = mem_a_q;
        dout_d   = dout_q;
        wr_d     = 1'b0;
        done_d   = 1'b0;
        ifdone_d = 1'b0;
        data_d   = data_q;
        inst_d   = inst_q;
`ifdef MEM_CTRL_IO_WAIT_EN
        io_d     = io_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (load | save) begin
                    addr_d = sl_reg_address[AW-1:0];
                    len_d  = req_len;
                    sgn_d  = sl_data_signed;
                    wdat_d = sl_data;
                    own_d  = 1'b0;
                    buf_d  = '0;
`ifdef MEM_CTRL_IO_WAIT_EN
                    io_d   = (sl_reg_address[17:16] == 2'b11);
`endif
                    if (load) begin
                        state_d = READ;
                        mem_a_d = sl_reg_address[AW-1:0];
                        cnt_d   = 3'd1;
                    end else begin
                        state_d = WRITE;
                        if (hold_idle) begin
                            cnt_d = 3'd0;
                        end else begin
                            wr_d    = 1'b1;
                            mem_a_d = sl_reg_address[AW-1:0];
                            dout_d  = sl_data[7:0];
                            cnt_d   = 3'd1;
                        end
                    end
                end else if (if_req) begin
                    addr_d  = if_addr[AW-1:0];
                    len_d   = 3'd4;
                    sgn_d   = 1'b0;
                    own_d   = 1'b1;
                    buf_d   = '0;
                    state_d = READ;
                    mem_a_d = if_addr[AW-1:0];
                    cnt_d   = 3'd1;
                end
            end
            READ: begin
                if (cnt_q < len_q) mem_a_d = addr_q + AW'(cnt_q);
                if (cnt_q >= 3'd2) buf_d = word;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == len_q + 3'd1) begin
                    state_d = DONE;
                    if (own_q) begin
                        ifdone_d = 1'b1;
                        inst_d   = word;
                    end else begin
                        done_d = 1'b1;
                        case (len_q)
                            3'd1:    data_d = {{24{sgn_q & word[7]}}, word[7:0]};
                            3'd2:    data_d = {{16{sgn_q & word[15]}}, word[15:0]};
                            default: data_d = word;
                        endcase
                    end
                end
            end
            WRITE: begin
                if (cnt_q == len_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (!hold_wr) begin
                    wr_d    = 1'b1;
                    mem_a_d = addr_q + AW'(cnt_q);
                    dout_d  = wbyte;
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= 3'd0;
            sgn_q    <= 1'b0;
            wdat_q   <= '0;
            own_q    <= 1'b0;
            cnt_q    <= 3'd0;
            buf_q    <= '0;
            mem_a_q  <= '0;
            dout_q   <= '0;
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
            ifdone_q <= 1'b0;
            data_q   <= '0;
            inst_q   <= '0;
`ifdef MEM_CTRL_IO_WAIT_EN
            io_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            sgn_q    <= sgn_d;
            wdat_q   <= wdat_d;
            own_q    <= own_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            mem_a_q  <= mem_a_d;
            dout_q   <= dout_d;
            wr_q     <= wr_d;
            done_q   <= done_d;
            ifdone_q <= ifdone_d;
            data_q   <= data_d;
            inst_q   <= inst_d;
`ifdef MEM_CTRL_IO_WAIT_EN
            io_q     <= io_d;
`endif
        end
    end

    assign mem_a         = mem_a_q;
    assign mem_dout      = dout_q;
    assign mem_wr        = wr_q;
    assign mem_ctrl_done = done_q;
    assign mem_ctrl_data = data_q;
    assign if_done       = ifdone_q;
    assign if_inst       = inst_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed + random bench for mem_ctrl with a byte-array RAM and reference model.
// IO wait scenario is included when MEM_CTRL_IO_WAIT_EN is defined.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load, save;
    logic [31:0] sl_reg_address, sl_data;
    logic [2:0]  sl_data_length;
    logic        sl_data_signed;
    logic        mem_ctrl_done;
    logic [31:0] mem_ctrl_data;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
`ifdef MEM_CTRL_IO_WAIT_EN
    logic        io_full;
`endif

    int total = 0;
    int bad = 0;

    logic [7:0] ram  [bit [31:0]];
    logic [7:0] gold [bit [31:0]];

    mem_ctrl #(.RAM_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .load(load), .save(save),
        .sl_reg_address(sl_reg_address), .sl_data(sl_data),
        .sl_data_length(sl_data_length), .sl_data_signed(sl_data_signed),
        .mem_ctrl_done(mem_ctrl_done), .mem_ctrl_data(mem_ctrl_data),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
`ifdef MEM_CTRL_IO_WAIT_EN
        , .io_buffer_full(io_full)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] gold_rd(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : dflt(a);
    endfunction

    // synchronous byte RAM: read data appears one cycle after the address
    always @(posedge clk) begin
        mem_din <= ram_rd(mem_a);
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    task automatic set_io(input bit v);
`ifdef MEM_CTRL_IO_WAIT_EN
        io_full = v;
`endif
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        ram[a]  = b;
        gold[a] = b;
    endtask

    function automatic int nbytes(input logic [2:0] lc);
        return (lc == 3'd1) ? 1 : (lc == 3'd2) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit s);
        longint v;
        v = 0;
        for (int i = 0; i < n; i++)
            v += longint'(gold_rd(a + 32'(i))) << (8 * i);
        if (s && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is at a sample point; the cycle it drives becomes cycle 0.
    task automatic txn(input bit dd, input bit st, input logic [31:0] a,
                       input logic [2:0] lc, input bit sg, input logic [31:0] wd,
                       input bit df, input logic [31:0] fa, input int w);
        int n, dc, fs, fc, last;
        bit exp_wr;
        logic [31:0] exp_d, exp_f;
`ifdef MEM_CTRL_IO_WAIT_EN
        if (!(dd && st && a[17:16] == 2'b11)) w = 0;
`else
        w = 0;
`endif
        n    = nbytes(lc);
        dc   = dd ? (st ? n + 1 + w : n + 2) : -1;
        fs   = dd ? dc + 1 : 0;
        fc   = df ? fs + 6 : -1;
        last = df ? fc : dc;
        exp_d = '0;
        if (dd && st)
            for (int i = 0; i < n; i++) gold[a + 32'(i)] = wd[8*i +: 8];
        if (dd && !st) exp_d = ref_load(a, n, sg);
        exp_f = df ? ref_load(fa, 4, 1'b0) : '0;
        load = dd && !st;
        save = dd && st;
        sl_reg_address = a;
        sl_data = wd;
        sl_data_length = lc;
        sl_data_signed = sg;
        if_req = df;
        if_addr = fa;
        set_io(w > 0);
        for (int c = 1; c <= last + 1; c++) begin
            tick();
            set_io(c < w);
            chk("data_done", 32'(mem_ctrl_done), 32'(dd && c == dc));
            chk("if_done", 32'(if_done), 32'(df && c == fc));
            exp_wr = dd && st && c >= 1 + w && c <= n + w;
            chk("mem_wr", 32'(mem_wr), 32'(exp_wr));
            if (exp_wr) begin
                chk("wr_addr", mem_a, a + 32'(c - 1 - w));
                chk("wr_byte", 32'(mem_dout), 32'(wd[8*(c-1-w) +: 8]));
            end
            if (dd && !st && c >= 1 && c <= n)
                chk("rd_addr", mem_a, a + 32'(c - 1));
            if (df && c >= fs + 1 && c <= fs + 4)
                chk("if_addr", mem_a, fa + 32'(c - fs - 1));
            if (dd && c == dc) begin
                if (!st) chk("load_data", mem_ctrl_data, exp_d);
                load = 1'b0;
                save = 1'b0;
            end
            if (df && c == fc) begin
                chk("if_inst", if_inst, exp_f);
                if_req = 1'b0;
            end
        end
        if (dd && st)
            for (int i = 0; i < n; i++)
                chk("ram_byte", 32'(ram_rd(a + 32'(i))), 32'(wd[8*i +: 8]));
    endtask

    initial begin
        logic [31:0] ra, rw;
        int kind;
        rst = 1'b1;
        load = 0; save = 0; if_req = 0;
        sl_reg_address = 0; sl_data = 0; sl_data_length = 0; sl_data_signed = 0;
        if_addr = 0;
        set_io(1'b0);
        repeat (3) tick();
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_done", 32'(mem_ctrl_done), 32'h0);
        chk("rst_data", mem_ctrl_data, 32'h0);
        chk("rst_if_done", 32'(if_done), 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        rst = 1'b0;
        tick();

        poke(32'h10, 8'h80);
        txn(1, 0, 32'h10, 3'd1, 1, 0, 0, 0, 0);
        chk("lb_const", mem_ctrl_data, 32'hFFFFFF80);

        poke(32'h21, 8'h34);
        poke(32'h22, 8'h92);
        txn(1, 0, 32'h21, 3'd2, 0, 0, 0, 0, 0);
        chk("lhu_const", mem_ctrl_data, 32'h00009234);
        txn(1, 0, 32'h21, 3'd2, 1, 0, 0, 0, 0);

        txn(1, 1, 32'h100, 3'd4, 0, 32'hDEADBEEF, 0, 0, 0);
        txn(1, 0, 32'h100, 3'd4, 0, 0, 0, 0, 0);
        chk("sw_readback", mem_ctrl_data, 32'hDEADBEEF);

        txn(1, 0, 32'h40, 3'd4, 0, 0, 1, 32'h80, 0);
        txn(1, 0, 32'hFFFFFFFE, 3'd0, 0, 0, 0, 0, 0);

        // reset in cycle 2 of a word store
        load = 0;
        save = 1;
        sl_reg_address = 32'h200;
        sl_data = 32'h11223344;
        sl_data_length = 3'd4;
        tick();
        chk("rs_wr_c1", 32'(mem_wr), 32'h1);
        chk("rs_byte_c1", 32'(mem_dout), 32'h44);
        tick();
        chk("rs_wr_c2", 32'(mem_wr), 32'h1);
        rst = 1'b1;
        save = 1'b0;
        tick();
        chk("rs_wr_c3", 32'(mem_wr), 32'h0);
        chk("rs_done_c3", 32'(mem_ctrl_done), 32'h0);
        chk("rs_mem_a_c3", mem_a, 32'h0);
        gold[32'h200] = 8'h44;
        gold[32'h201] = 8'h33;
        tick();
        rst = 1'b0;
        chk("rs_done_c4", 32'(mem_ctrl_done), 32'h0);
        txn(1, 0, 32'h200, 3'd4, 0, 0, 0, 0, 0);

`ifdef MEM_CTRL_IO_WAIT_EN
        txn(1, 1, 32'h30000, 3'd1, 0, 32'h41, 0, 0, 5);
        txn(1, 1, 32'h30010, 3'd4, 0, 32'hCAFEF00D, 0, 0, 2);
`endif

        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 3));
            ra = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63))
                                            : 32'hFFFFFFC0 + 32'($urandom_range(0, 63));
            rw = $urandom;
            case (kind)
                0: txn(1, 0, ra, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       rw, 0, 0, 0);
                1: txn(1, 1, ra, 3'($urandom_range(0, 7)), 0, rw, 0, 0,
                       int'($urandom_range(0, 3)));
                2: txn(0, 0, 0, 0, 0, 0, 1, ra, 0);
                default: txn(1, 0, ra, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                             rw, 1, 32'($urandom_range(0, 127)), 0);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
